scoreboard_register_file: RTL
=============================

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 SHALL have parameter BIT_COUNT, default 32, data width of every register.
REQ-002 SHALL have parameter REGISTER_COUNT, default 32, number of architectural registers, power of two and at least 4.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 SHALL define localparam AW = $clog2(REGISTER_COUNT) and CW = $clog2(REGISTER_COUNT+1).
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port WriteEnable  in  1  writeback strobe.
REQ-008 SHALL have port rdAdr  in  AW  writeback register address.
REQ-009 SHALL have port Rd  in  BIT_COUNT  writeback data.
REQ-010 SHALL have ports rs1Adr and rs2Adr  in  AW  read addresses.
REQ-011 SHALL have ports Rs1 and Rs2  out  BIT_COUNT  read data.
REQ-012 SHALL have ports Rs1Busy and Rs2Busy  out  1  source has a pending write.
REQ-013 SHALL have port IssueValid  in  1  instruction requests issue.
REQ-014 SHALL have port IssueHasDest  in  1  issuing instruction writes a register.
REQ-015 SHALL have port issueAdr  in  AW  destination register to reserve.
REQ-016 SHALL have port IssueStall  out  1  issue refused this cycle.
REQ-017 SHALL have port Flush  in  1  clear all reservations.
REQ-018 SHALL have port BusyCount  out  CW  number of reserved registers.

Function
REQ-019 Reads SHALL be combinational: Rs1/Rs2 = register[rs1Adr/rs2Adr], zero-latency.
REQ-020 Writeback SHALL update register[rdAdr] with Rd at the rising edge when WriteEnable = 1.
REQ-021 With ZERO_REG = 1, writes to register 0 SHALL be discarded; register 0 SHALL always read 0 and never be busy.
REQ-022 Each register SHALL own one busy bit; RsNBusy = busy[rsNAdr].
REQ-023 IssueStall SHALL = IssueValid & (Rs1Busy | Rs2Busy | (IssueHasDest & busy[issueAdr])), combinationally; stall covers RAW and WAW.
REQ-024 Issue SHALL be accepted when IssueValid = 1 and IssueStall = 0; if IssueHasDest = 1 and issueAdr is not a hardwired zero, busy[issueAdr] SHALL set next edge.
REQ-025 WriteEnable = 1 SHALL clear busy[rdAdr] next edge, whether or not that bit is set.
REQ-026 Same-edge accepted issue and writeback to the same address SHALL leave busy set (new reservation wins).
REQ-027 Flush = 1 SHALL clear all busy bits next edge, overriding same-cycle issue reservation; a same-cycle register write SHALL still occur.
REQ-028 BusyCount SHALL be a registered population count of the busy bits, updated the same edge as the bits, never exceeding REGISTER_COUNT - ZERO_REG.
REQ-029 IssueStall SHALL be 0 whenever IssueValid = 0.

Reset
REQ-030 Asserting reset (low) SHALL asynchronously set every register to 0, every busy bit to 0, and BusyCount to 0.
REQ-031 While reset is low, Rs1 = Rs2 = 0, Rs1Busy = Rs2Busy = 0, IssueStall = IssueValid & 0 = 0.
REQ-032 Reset asserted mid-operation SHALL discard all reservations and pending writes; the first edge after deassertion SHALL behave as from cold.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN SHALL, when defined, forward Rd to RsN when WriteEnable = 1 and rdAdr = rsNAdr (non-zero register), and force RsNBusy = 0 for that address in that cycle, so IssueStall uses the bypassed busy value.
REQ-034 Without REGFILE_BYPASS_EN, reads SHALL return the pre-edge register value and pre-edge busy bit; a dependent instruction stalls one extra cycle.

Verification
REQ-035 Reset low with registers dirty -> all reads 0, BusyCount = 0, registers stay 0 after release until written.
REQ-036 Issue dest x5, next cycle issue rs1Adr = 5 -> IssueStall = 1, Rs1Busy = 1, BusyCount = 1; writeback x5 = 0xDEADBEEF -> busy clears, next read Rs1 = 0xDEADBEEF, BusyCount = 0.
REQ-037 Same cycle WriteEnable rdAdr = 7, Rd = 0x55 and rs2Adr = 7 -> Rs2 = 0x55 and Rs2Busy = 0 with REGFILE_BYPASS_EN; old value and Rs2Busy = 1 without it.
REQ-038 Write 0x1234 to x0 and issue dest x0 with ZERO_REG = 1 -> Rs1 at rs1Adr = 0 is 0, BusyCount unchanged, no stall.
REQ-039 Same-edge accepted issue dest x9 and writeback x9 -> busy[9] = 1 afterwards; then Flush with issue dest x3 -> all busy 0, BusyCount = 0.
REQ-040 Reserve all 31 non-zero registers -> BusyCount = 31; issue dest x4 again -> IssueStall = 1 (WAW), no count change.

Source files
------------

// File: rtl/scoreboard_register_file.sv
// -----------------------------------------------------------------------------
// scoreboard_register_file
//
// Architectural register file with a per-register busy scoreboard for an
// in-order issue stage. Two combinational read ports, one writeback port and
// one issue port. An issuing instruction stalls while one of its sources is
// reserved by an older instruction (RAW), or while its destination is already
// reserved (WAW). An accepted issue with a destination reserves that register.
// Writeback releases the reservation. Flush drops every reservation.
//
// Parameters
//   BIT_COUNT       data width of every register
//   REGISTER_COUNT  number of registers (power of two, >= 4)
//   ZERO_REG        1: register 0 reads as zero, ignores writes, never busy
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous active-low reset
//   WriteEnable   writeback strobe
//   rdAdr, Rd     writeback address / data
//   rs1Adr/rs2Adr read addresses
//   Rs1/Rs2       read data
//   Rs1Busy/Rs2Busy  source register has a pending write
//   IssueValid    instruction requests issue
//   IssueHasDest  issuing instruction writes a register
//   issueAdr      destination register to reserve
//   IssueStall    issue refused this cycle
//   Flush         clear all reservations
//   BusyCount     registered count of reserved registers
//
// Build option
//   REGFILE_BYPASS_EN  when defined, same-cycle writeback data is forwarded
//                      to the read ports and the matching busy bit reads 0.
//                      Undefined: reads show pre-edge value and busy bit.
// -----------------------------------------------------------------------------
module scoreboard_register_file #(
    parameter int BIT_COUNT      = 32,
    parameter int REGISTER_COUNT = 32,
    parameter int ZERO_REG       = 1,
    localparam int AW = $clog2(REGISTER_COUNT),
    localparam int CW = $clog2(REGISTER_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 WriteEnable,
    input  logic [AW-1:0]        rdAdr,
    input  logic [BIT_COUNT-1:0] Rd,
    input  logic [AW-1:0]        rs1Adr,
    input  logic [AW-1:0]        rs2Adr,
    output logic [BIT_COUNT-1:0] Rs1,
    output logic [BIT_COUNT-1:0] Rs2,
    output logic                 Rs1Busy,
    output logic                 Rs2Busy,
    input  logic                 IssueValid,
    input  logic                 IssueHasDest,
    input  logic [AW-1:0]        issueAdr,
    output logic                 IssueStall,
    input  logic                 Flush,
    output logic [CW-1:0]        BusyCount
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [BIT_COUNT-1:0]      regs [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] busy;
    logic [REGISTER_COUNT-1:0] busy_next;
    logic [CW-1:0]             busy_count;
    logic [CW-1:0]             busy_count_next;

    logic wb_to_reg;     // writeback that actually lands in a register
    logic issue_accept;  // issue handshake completes this cycle
    logic issue_reserve; // accepted issue that reserves a real register

    // Writes aimed at a hardwired-zero register vanish here, so register 0
    // keeps its reset value of zero and needs no special case on the read side.
    assign wb_to_reg = WriteEnable && !(ZERO_EN && (rdAdr == '0));

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path through the block leaves it unassigned (no latch inferred).
        Rs1     = regs[rs1Adr];
        Rs2     = regs[rs2Adr];
        Rs1Busy = busy[rs1Adr];
        Rs2Busy = busy[rs2Adr];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by reset so the ports read zero while the
        // block is held in reset even if a writeback is being driven.
        if (reset && wb_to_reg && (rdAdr == rs1Adr)) begin
            Rs1     = Rd;
            Rs1Busy = 1'b0;
        end
        if (reset && wb_to_reg && (rdAdr == rs2Adr)) begin
            Rs2     = Rd;
            Rs2Busy = 1'b0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Issue control: RAW on either source, WAW on the destination
    // ------------------------------------------------------------------
    assign IssueStall    = IssueValid &
                           (Rs1Busy | Rs2Busy | (IssueHasDest & busy[issueAdr]));
    assign issue_accept  = IssueValid && !IssueStall;
    assign issue_reserve = issue_accept && IssueHasDest &&
                           !(ZERO_EN && (issueAdr == '0));

    // ------------------------------------------------------------------
    // Next busy vector. Order of the updates sets priority:
    // writeback clear < new reservation < flush.
    // ------------------------------------------------------------------
    always_comb begin
        busy_next = busy;
        if (WriteEnable) begin
            busy_next[rdAdr] = 1'b0;
        end
        if (issue_reserve) begin
            busy_next[issueAdr] = 1'b1;
        end
        if (Flush) begin
            busy_next = '0;
        end
        if (ZERO_EN) begin
            busy_next[0] = 1'b0;
        end
    end

    // Population count of the next busy vector, registered alongside it so
    // BusyCount always matches the busy bits of the same cycle.
    always_comb begin
        busy_count_next = '0;
        for (int i = 0; i < REGISTER_COUNT; i++) begin
            busy_count_next = busy_count_next + CW'(busy_next[i]);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the register array is cleared by reset on purpose: reads
            // must return zero during and after reset until first written,
            // so this storage cannot be mapped to a reset-less RAM.
            for (int i = 0; i < REGISTER_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_to_reg) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            regs[rdAdr] <= Rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count_next;
        end
    end

    assign BusyCount = busy_count;

endmodule
